// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: accepts one instruction per
// handshake, drives registered operands from R0-R3 and writes back result/flags.
module alu_issue_ctrl #(
    parameter int                 DATA_W   = 8,
    parameter logic [DATA_W-1:0]  REG_INIT = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    output logic              done,
    output logic              err,
    output logic              flag_z,
    output logic              flag_v,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RETIRE
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        rd_q, rd_d;
    logic [7:0]        imm_q, imm_d;
    logic [2:0]        alu_opcode_q, alu_opcode_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] regs_d [4];
    logic              flag_z_q, flag_z_d;
    logic              flag_v_q, flag_v_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        regs_d       = regs_q;
        flag_z_d     = flag_z_q;
        flag_v_d     = flag_v_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d         = in_instr[15:13];
                    rd_d         = in_instr[12:11];
                    imm_d        = in_instr[7:0];
                    alu_opcode_d = in_instr[15:13];
                    alu_a_d      = regs_q[in_instr[12:11]];
                    alu_b_d      = in_instr[8] ? in_instr[7:0] : regs_q[in_instr[10:9]];
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // done/err are registered here so they appear during RETIRE
                case (op_q)
                    OP_ADD, OP_AND, OP_NOT: begin
                        regs_d[rd_q] = alu_res;
                        flag_z_d     = alu_zero;
                        flag_v_d     = alu_ovf;
                    end
                    OP_LDI: begin
                        regs_d[rd_q] = imm_q;
                        flag_z_d     = (imm_q == 8'h00);
                        flag_v_d     = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
                done_d  = 1'b1;
                state_d = RETIRE;
            end
            RETIRE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            for (int unsigned i = 0; i < 4; i++) regs_q[i] <= REG_INIT;
            flag_z_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            regs_q       <= regs_d;
            flag_z_q     <= flag_z_d;
            flag_v_q     <= flag_v_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign done       = done_q;
    assign err        = err_q;
    assign flag_z     = flag_z_q;
    assign flag_v     = flag_v_q;
    assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed table-driven bench for alu_issue_ctrl with a behavioural ALU model
// and a hand-written mid-instruction reset sequence.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic        alu_zero, alu_ovf;
    logic        done, err, flag_z, flag_v;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .REG_INIT(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .done       (done),
        .err        (err),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Reference ALU: ADD/AND/NOT, signed overflow on ADD only
    logic [7:0] r_tmp;
    always_comb begin
        r_tmp   = 8'h00;
        alu_ovf = 1'b0;
        case (alu_opcode)
            3'b000: begin
                r_tmp   = alu_a + alu_b;
                alu_ovf = (alu_a[7] == alu_b[7]) && (r_tmp[7] != alu_a[7]);
            end
            3'b001:  r_tmp = alu_a & alu_b;
            3'b010:  r_tmp = ~alu_a;
            default: r_tmp = 8'h00;
        endcase
        alu_res  = r_tmp;
        alu_zero = (r_tmp == 8'h00);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       ui;
        logic [7:0] imm;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] eres;
        logic       ez;
        logic       ev;
        logic       eerr;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mkv(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                                 input logic ui, input logic [7:0] imm, input logic [7:0] ea,
                                 input logic [7:0] eb, input logic [7:0] eres, input logic ez,
                                 input logic ev, input logic eerr);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.ui = ui; v.imm = imm;
        v.ea = ea; v.eb = eb; v.eres = eres; v.ez = ez; v.ev = ev; v.eerr = eerr;
        return v;
    endfunction

    // Full handshake: accept at E0, EXEC checks, RETIRE checks, back to IDLE
    task automatic run_vec(input int i);
        vec_t v;
        v = vt[i];
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", i), in_ready, 1);
        dbg_addr = v.rd;
        in_valid = 1'b1;
        in_instr = {v.op, v.rd, v.rs, v.ui, v.imm};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 16'hFFFF;
        @(negedge clk);
        chk($sformatf("v%0d_ready_exec", i), in_ready, 0);
        chk($sformatf("v%0d_done_exec", i), done, 0);
        chk($sformatf("v%0d_alu_op", i), alu_opcode, v.op);
        chk($sformatf("v%0d_alu_a", i), alu_a, v.ea);
        chk($sformatf("v%0d_alu_b", i), alu_b, v.eb);
        @(negedge clk);
        chk($sformatf("v%0d_ready_ret", i), in_ready, 0);
        chk($sformatf("v%0d_done", i), done, 1);
        chk($sformatf("v%0d_err", i), err, v.eerr);
        chk($sformatf("v%0d_reg", i), dbg_data, v.eres);
        chk($sformatf("v%0d_z", i), flag_z, v.ez);
        chk($sformatf("v%0d_v", i), flag_v, v.ev);
        @(negedge clk);
        chk($sformatf("v%0d_done_off", i), done, 0);
        chk($sformatf("v%0d_err_off", i), err, 0);
        chk($sformatf("v%0d_ready_back", i), in_ready, 1);
    endtask

    initial begin
        //            op     rd     rs     ui    imm    ea     eb     res    z  v  err
        vt[0]  = mkv(3'd3, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h00, 8'h0F, 8'h0F, 0, 0, 0); // LDI R1,#0F
        vt[1]  = mkv(3'd3, 2'd2, 2'd0, 1'b1, 8'h01, 8'h00, 8'h01, 8'h01, 0, 0, 0); // LDI R2,#01
        vt[2]  = mkv(3'd0, 2'd1, 2'd2, 1'b0, 8'h00, 8'h0F, 8'h01, 8'h10, 0, 0, 0); // ADD R1,R2
        vt[3]  = mkv(3'd3, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h00, 8'h7F, 8'h7F, 0, 0, 0); // LDI R0,#7F
        vt[4]  = mkv(3'd0, 2'd0, 2'd0, 1'b1, 8'h01, 8'h7F, 8'h01, 8'h80, 0, 1, 0); // ADD R0,#1
        vt[5]  = mkv(3'd3, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 0, 0, 0); // LDI R3,#FF
        vt[6]  = mkv(3'd0, 2'd3, 2'd0, 1'b1, 8'h01, 8'hFF, 8'h01, 8'h00, 1, 0, 0); // ADD R3,#1
        vt[7]  = mkv(3'd3, 2'd1, 2'd0, 1'b1, 8'hCC, 8'h10, 8'hCC, 8'hCC, 0, 0, 0); // LDI R1,#CC
        vt[8]  = mkv(3'd3, 2'd2, 2'd0, 1'b1, 8'hAA, 8'h01, 8'hAA, 8'hAA, 0, 0, 0); // LDI R2,#AA
        vt[9]  = mkv(3'd1, 2'd1, 2'd2, 1'b0, 8'h00, 8'hCC, 8'hAA, 8'h88, 0, 0, 0); // AND R1,R2
        vt[10] = mkv(3'd3, 2'd1, 2'd0, 1'b1, 8'h0F, 8'h88, 8'h0F, 8'h0F, 0, 0, 0); // LDI R1,#0F
        vt[11] = mkv(3'd2, 2'd1, 2'd2, 1'b0, 8'h00, 8'h0F, 8'hAA, 8'hF0, 0, 0, 0); // NOT R1
        vt[12] = mkv(3'd3, 2'd0, 2'd0, 1'b1, 8'h00, 8'h80, 8'h00, 8'h00, 1, 0, 0); // LDI R0,#0
        vt[13] = mkv(3'd5, 2'd2, 2'd1, 1'b0, 8'h00, 8'hAA, 8'hF0, 8'hAA, 1, 0, 1); // illegal
        vt[14] = mkv(3'd0, 2'd2, 2'd2, 1'b0, 8'h00, 8'hAA, 8'hAA, 8'h54, 0, 1, 0); // ADD R2,R2
        vt[15] = mkv(3'd3, 2'd3, 2'd0, 1'b1, 8'h05, 8'h00, 8'h05, 8'h05, 0, 0, 0); // LDI R3,#05

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_addr = 2'd0;

        repeat (2) @(negedge clk);
        chk("rst_alu_op", alu_opcode, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_flag_z", flag_z, 0);
        chk("rst_flag_v", flag_v, 0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk($sformatf("rst_R%0d", r), dbg_data, 8'h00);
        end
        rst_n = 1'b1;

        // Idle with no valid: nothing retires, controller stays ready
        repeat (2) begin
            @(negedge clk);
            chk("idle_ready", in_ready, 1);
            chk("idle_done", done, 0);
        end

        for (int i = 0; i < 15; i++) run_vec(i);

        // Reset during EXEC of ADD R0,#1 must abort with no writeback or done
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {3'd0, 2'd0, 2'd0, 1'b1, 8'h01};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_exec", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_done", done, 0);
        chk("abort_flag_z", flag_z, 0);
        chk("abort_flag_v", flag_v, 0);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk($sformatf("abort_R%0d", r), dbg_data, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", in_ready, 1);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            dbg_addr = 2'd0;
            #1;
            chk("abort_R0_kept", dbg_data, 8'h00);
        end

        run_vec(15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives the 8-bit combinational ALU from the other side: accepts one instruction per valid/ready handshake and reads operands from an internal 4-entry register file.
- Presents registered opcode/operands to the ALU, then captures the result and flags and writes back.
- Sits between instruction fetch and the ALU in the CPU datapath. It owns the architectural registers R0-R3 and the Z/V flag register.

Parameters:
- DATA_W, 8, datapath width; must match the ALU (only 8 is supported).
- REG_INIT, 8'h00, reset value of R0-R3.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction valid.
- in_ready  output  1  controller can accept an instruction.
- in_instr  input  16  [15:13] op, [12:11] rd, [10:9] rs, [8] use_imm, [7:0] imm.
- alu_opcode  output  3  registered opcode to ALU.
- alu_a  output  8  registered operand A to ALU.
- alu_b  output  8  registered operand B to ALU.
- alu_res  input  8  ALU result, combinational from alu_*.
- alu_zero  input  1  ALU zero flag.
- alu_ovf  input  1  ALU signed-overflow flag.
- done  output  1  one-cycle pulse: instruction retired.
- err  output  1  one-cycle pulse with done: illegal op.
- flag_z  output  1  architectural zero flag.
- flag_v  output  1  architectural overflow flag.
- dbg_addr  input  2  register-file debug read address.
- dbg_data  output  8  R[dbg_addr], combinational.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; R0-R3=REG_INIT.
  - alu_opcode=3'b000, alu_a=alu_b=0.
  - done=err=0, flag_z=flag_v=0.
  - in_ready=1 once rst_n deasserts.
  - Reset mid-instruction aborts it: no writeback, no done.
- Ops:
  - 000 ADD, 001 AND, 010 NOT: ALU ops.
  - 011 LDI: rd<=imm, no ALU use.
  - 100-111: illegal.
- FSM states IDLE, EXEC, RETIRE:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0, latch the instruction and go to EXEC. At E0 also load:
    - alu_opcode<=op[2:0];
    - alu_a<=R[rd];
    - alu_b<=use_imm ? imm : R[rs].
    - If in_valid=0, stay in IDLE.
  - EXEC (one cycle): in_ready=0; ALU settles combinationally. At edge E1:
    - ADD/AND/NOT: R[rd]<=alu_res; flag_z<=alu_zero; flag_v<=alu_ovf.
    - LDI: R[rd]<=imm; flag_z<=(imm==0); flag_v<=0.
    - Illegal: no register or flag change.
    - Go to RETIRE.
  - RETIRE (one cycle): done=1, err=1 iff illegal, in_ready=0. Then go to IDLE.
- done/err are registered, asserted only in RETIRE.
- Latency: handshake edge E0 -> writeback visible on dbg_data/flags after E1 -> done high in the cycle after E1. Throughput: one instruction per 3 cycles.
- alu_* hold their last values outside EXEC; they are reloaded only at accept.
- NOT: alu_b is still loaded per use_imm/rs but the ALU ignores it.
- rd==rs is legal; the operand is read before writeback.
- Writes occur only at E1. dbg_data reflects the new value from the cycle after E1.
- in_instr is sampled only at the handshake edge; changes while in_ready=0 are ignored.
- Arithmetic is modulo 2^8, performed by the ALU. The controller does no arithmetic except the LDI zero test.

Test Plan:
- Reset then LDI R1,#15 and LDI R2,#1 -> dbg R1=0x0F, R2=0x01; flag_z=0; each done pulses 1 cycle, 2 cycles after accept; in_ready low for exactly 2 cycles per instruction.
- ADD R1,R2 (reg) after loads -> alu_opcode=000, alu_a=0x0F, alu_b=0x01 during EXEC; R1=0x10, Z=0, V=0.
- LDI R0,#0x7F; ADD R0,#1 (imm) -> R0=0x80, V=1. Then LDI R3,#0xFF; ADD R3,#1 -> R3=0x00, Z=1, V=0.
- AND R1(0xCC),R2(0xAA) -> R1=0x88, Z=0; NOT R1 on 0x0F -> 0xF0. LDI R0,#0 -> Z=1, V=0.
- Illegal op 3'b101 -> done and err both high one cycle; registers and flags unchanged; next instruction accepted normally.
- Assert rst_n low during EXEC of ADD -> no writeback, no done; all regs 0x00, flags 0; in_ready=1 after release.
